rip_bram_port_arbiter: RTL
==========================

// Module: rip_bram_port_arbiter
// PURPOSE
//  Shares the read/write port (port 1) of a 2-read 1-write BRAM between two requesters (m0, m1).
//  Round-robin arbitration, valid/ready request handshake, fixed 1-cycle response.
//  Sits between the core's data-memory/reservoir access paths and the BRAM. Port 2 is not touched.
// PARAMETERS
//  DATA_WIDTH  32  word width; multiple of B_WIDTH (rip_const, 8)
//  ADDR_WIDTH  10  word address width; depth = 2**ADDR_WIDTH
//  NBE         DATA_WIDTH/B_WIDTH (localparam)  byte-enable width
// PORTS
//  clk          in   1           clock
//  rstn         in   1           synchronous active-low reset
//  m0_valid     in   1           m0 request valid
//  m0_ready     out  1           m0 request accepted this cycle
//  m0_addr      in   ADDR_WIDTH  m0 word address
//  m0_we        in   NBE         m0 byte write enables (0 = read)
//  m0_wdata     in   DATA_WIDTH  m0 write data
//  m0_rvalid    out  1           m0 response valid
//  m0_rdata     out  DATA_WIDTH  m0 response data
//  m1_*         --   --          same set as m0, for requester 1
//  bram_en      out  1           BRAM port-1 enable
//  bram_addr    out  ADDR_WIDTH  BRAM port-1 address
//  bram_we      out  NBE         BRAM port-1 byte enables
//  bram_din     out  DATA_WIDTH  BRAM port-1 write data
//  bram_dout    in   DATA_WIDTH  BRAM port-1 read data (1-cycle latency, read-first)
//  init_done    out  1           1 when arbiter accepts requests
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): prio<=0 (m0 favoured), rsp_owner/rsp_pend<=0, m*_rvalid<=0,
//    m*_rdata<=0, state<=S_INIT if RIP_BRAM_INIT_EN else S_RUN. Reset mid-transfer drops the
//    in-flight response; no rvalid afterwards.
//  - FSM: S_INIT -> S_RUN when clear counter reaches 2**ADDR_WIDTH-1; S_RUN is terminal until reset.
//  - In S_RUN, combinational grant: only m0 valid -> m0; only m1 -> m1; both -> prio side.
//    mX_ready = grant to X. At most one ready per cycle. ready never asserted in S_INIT.
//  - Granted request drives bram_en=1, bram_addr/we/din from that master, same cycle (no register).
//    No grant -> bram_en=0, bram_we=0, addr/din don't-care (drive 0).
//  - prio updates only when both are valid in the same cycle: prio <= ~winner. Single-requester grants leave prio.
//  - Handshake: master holds valid/addr/we/wdata stable until ready; deasserting valid before
//    ready is legal (request withdrawn, nothing issued).
//  - Response: every accepted request (read or write) yields mX_rvalid=1 exactly the next cycle,
//    for one cycle, on the granting master only; mX_rdata = bram_dout (old word on writes).
//    Non-owner rdata holds previous value. No response backpressure; throughput 1 req/cycle.
//  - Back-to-back: alternating grants under continuous contention (m0,m1,m0,...); responses pipelined.
//  - Same-address write then read from other master next cycle returns the new data.
//  - Address wraps modulo 2**ADDR_WIDTH inherently; no range check.
// CONFIGURATION
//  RIP_BRAM_INIT_EN defined: after reset, S_INIT sweeps addr 0..2**ADDR_WIDTH-1, one per cycle,
//    bram_en=1, bram_we=all ones, bram_din=0; init_done=0 throughout, rises the cycle after the
//    last write; m*_ready=0, m*_rvalid=0 during sweep. Reset during sweep restarts at addr 0.
//  Not defined: no S_INIT, no counter; init_done=1 from the first cycle after reset, BRAM contents
//    untouched.
// TESTING
//  1. Reset, m0 write addr 5 we=4'hF wdata=32'hDEADBEEF, then m0 read addr 5 -> m0_rvalid next cycle, rdata=32'hDEADBEEF.
//  2. m0,m1 both valid 4 cycles, distinct addrs -> grants m0,m1,m0,m1; each rvalid 1 cycle after its grant.
//  3. Byte write: addr 3 holds 32'h11223344, m1 we=4'b0010 wdata=32'hxxxxAAxx -> read gives 32'h1122AA44.
//  4. m1 alone for 3 cycles then both valid -> m0 wins first contended cycle (prio unchanged at 0).
//  5. rstn low the cycle after an accepted read -> no rvalid; arbiter restarts with prio=0.
//  6. RIP_BRAM_INIT_EN, ADDR_WIDTH=4: preloaded data, reset -> 16 clear writes, init_done at cycle 17,
//     ready low until then; any read afterwards returns 0.

Source files
------------

// File: rtl/rip_bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port 1 between two valid/ready requesters with a fixed 1-cycle response.
// Optional post-reset zero sweep of the whole BRAM is enabled by defining RIP_BRAM_INIT_EN.
module rip_bram_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    localparam int unsigned B_WIDTH   = 8,
    localparam int unsigned NBE       = DATA_WIDTH / B_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [NBE-1:0]        m0_we,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [NBE-1:0]        m1_we,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [NBE-1:0]        bram_we,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  init_done
);

    logic                  run;
    logic                  sweep;
    logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef RIP_BRAM_INIT_EN
    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_q, clr_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_INIT;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == S_INIT) begin
            clr_d = clr_q + 1'b1;
            if (clr_q == '1) begin
                state_d = S_RUN;
            end
        end
    end

    assign run        = rstn && (state_q == S_RUN);
    assign sweep      = rstn && (state_q == S_INIT);
    assign sweep_addr = clr_q;
    assign init_done  = (state_q == S_RUN);
`else
    assign run        = rstn;
    assign sweep      = 1'b0;
    assign sweep_addr = '0;
    assign init_done  = 1'b1;
`endif

    logic                  prio_q, prio_d;
    logic                  gnt0, gnt1;
    logic                  rv0_q, rv1_q;
    logic [DATA_WIDTH-1:0] rd0_q, rd1_q;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        prio_d    = prio_q;
        bram_en   = 1'b0;
        bram_addr = '0;
        bram_we   = '0;
        bram_din  = '0;
        if (run) begin
            gnt0 = m0_valid && (!m1_valid || !prio_q);
            gnt1 = m1_valid && (!m0_valid ||  prio_q);
        end
        // Priority only moves on contention: favour the loser next time.
        if (m0_valid && m1_valid && (gnt0 || gnt1)) begin
            prio_d = gnt0;
        end
        if (sweep) begin
            bram_en   = 1'b1;
            bram_addr = sweep_addr;
            bram_we   = '1;
        end else if (gnt0) begin
            bram_en   = 1'b1;
            bram_addr = m0_addr;
            bram_we   = m0_we;
            bram_din  = m0_wdata;
        end else if (gnt1) begin
            bram_en   = 1'b1;
            bram_addr = m1_addr;
            bram_we   = m1_we;
            bram_din  = m1_wdata;
        end
    end

    assign m0_ready = gnt0;
    assign m1_ready = gnt1;

    // rvalid is masked by rstn so a reset in the response cycle drops the response.
    assign m0_rvalid = rv0_q && rstn;
    assign m1_rvalid = rv1_q && rstn;
    assign m0_rdata  = m0_rvalid ? bram_dout : rd0_q;
    assign m1_rdata  = m1_rvalid ? bram_dout : rd1_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prio_q <= 1'b0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
            rd0_q  <= '0;
            rd1_q  <= '0;
        end else begin
            prio_q <= prio_d;
            rv0_q  <= gnt0;
            rv1_q  <= gnt1;
            if (m0_rvalid) begin
                rd0_q <= bram_dout;
            end
            if (m1_rvalid) begin
                rd1_q <= bram_dout;
            end
        end
    end

endmodule
